// File: rtl/poly_delay_line.sv
// poly_delay_line
//   Multi-channel programmable delay line. Each of NCH channels owns a
//   2^AW-word circular buffer in one shared block RAM, addressed
//   {channel, pointer}. An accepted sample is written at the channel's
//   write pointer. The word written len[c] samples earlier on that channel
//   comes out one cycle later. len 0 returns the incoming sample itself.
//   A clear sweep zeroes the whole RAM. The sweep runs after every reset
//   and whenever clear_req is seen in IDLE.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ch/in_data   sample input; in_ready high when accepted
//   out_valid/out_ch/out_data delayed sample, strobed 1 cycle after accept
//   cfg_we/cfg_ch/cfg_len    per-channel delay length write (any state)
//   clear_req           start a RAM clear sweep (ignored while sweeping)
//   busy                high while the clear sweep runs
module poly_delay_line #(
   parameter int DW  = 18,
   parameter int AW  = 11,
   parameter int NCH = 8,
   parameter int CW  = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [CW-1:0] in_ch,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [CW-1:0] out_ch,
   output logic [DW-1:0] out_data,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [AW-1:0] cfg_len,
   input  logic          clear_req,
   output logic          busy
);

   localparam int MW = CW + AW;
   localparam logic [MW-1:0] LAST_ADDR = {MW{1'b1}};

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [MW-1:0]          clr_cnt_q, clr_cnt_d;
   logic [NCH-1:0][AW-1:0] wp_q, wp_d;
   logic [NCH-1:0][AW-1:0] len_q, len_d;
   logic                   in_ready_q, in_ready_d;
   logic                   busy_q, busy_d;
   logic                   out_valid_q, out_valid_d;
   logic [CW-1:0]          out_ch_q, out_ch_d;
   logic                   byp_q, byp_d;
   logic [DW-1:0]          byp_data_q, byp_data_d;

   logic          accept;
   logic [AW-1:0] cur_wp, cur_len;

   // Single-port-write / single-port-read RAM, no reset, so it maps to block RAM.
   logic [DW-1:0] mem [0:(1<<MW)-1];
   logic          mem_we, mem_re;
   logic [MW-1:0] mem_wa, mem_ra;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd_q;

   assign accept  = in_valid & in_ready_q;
   assign cur_wp  = wp_q[in_ch];
   assign cur_len = len_q[in_ch];

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      wp_d        = wp_q;
      len_d       = len_q;
      out_valid_d = accept;
      out_ch_d    = out_ch_q;
      byp_d       = byp_q;
      byp_data_d  = byp_data_q;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_wa      = clr_cnt_q;
      mem_wd      = '0;
      mem_ra      = {in_ch, cur_wp - cur_len};

      if (accept) begin
         mem_re         = 1'b1;
         mem_we         = 1'b1;
         mem_wa         = {in_ch, cur_wp};
         mem_wd         = in_data;
         wp_d[in_ch]    = cur_wp + AW'(1);
         out_ch_d       = in_ch;
         // len 0 would read the slot being written this cycle; the RAM
         // returns old data there, so the sample is forwarded instead.
         byp_d          = (cur_len == '0);
         byp_data_d     = in_data;
      end

      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         CLEAR: begin
            // accept is low here, so the write port is free for the sweep.
            mem_we    = 1'b1;
            mem_wa    = clr_cnt_q;
            mem_wd    = '0;
            clr_cnt_d = clr_cnt_q + MW'(1);
            wp_d      = '0;
            if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
         end
         default: state_d = CLEAR;
      endcase

      // Applied after the sample so a same-channel sample keeps the old length.
      if (cfg_we) len_d[cfg_ch] = cfg_len;

      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d == CLEAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
         wp_q        <= '0;
         len_q       <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b1;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         // Reset looks like a bypass of a zero sample, giving out_data = 0
         // without needing a reset on the RAM output register.
         byp_q       <= 1'b1;
         byp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         wp_q        <= wp_d;
         len_q       <= len_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         byp_q       <= byp_d;
         byp_data_q  <= byp_data_d;
      end
   end

   // Read-before-write: the read samples the array before this edge's write.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      if (mem_re) mem_rd_q <= mem[mem_ra];
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = byp_q ? byp_data_q : mem_rd_q;

endmodule

// File: tb/tb_poly_delay_line.sv
module tb_poly_delay_line;

   localparam int DW = 18;
   localparam int AW = 11;
   localparam int NCH = 8;
   localparam int CW = 3;
   localparam int SWEEP = NCH * (1 << AW);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [CW-1:0] in_ch;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [CW-1:0] out_ch;
   logic [DW-1:0] out_data;
   logic          cfg_we;
   logic [CW-1:0] cfg_ch;
   logic [AW-1:0] cfg_len;
   logic          clear_req;
   logic          busy;

   poly_delay_line #(.DW(DW), .AW(AW), .NCH(NCH), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_len(cfg_len),
      .clear_req(clear_req), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [CW-1:0] ich;
      logic [DW-1:0] idat;
      logic          cw;
      logic [CW-1:0] cch;
      logic [AW-1:0] clen;
      logic          clr;
      logic          ev;
      logic [CW-1:0] ech;
      logic [DW-1:0] edat;
   } vec_t;

   vec_t          tbl[$];
   logic [CW-1:0] lch;
   logic [DW-1:0] ldat;
   int            n_run = 0;
   int            n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Sample vector: optional cfg in the same cycle; expected output becomes the held value.
   task automatic add_s(input logic [CW-1:0] ch, input logic [DW-1:0] d, input logic [DW-1:0] e,
                        input logic cw, input logic [CW-1:0] cch, input logic [AW-1:0] clen);
      vec_t v;
      v.iv = 1'b1; v.ich = ch; v.idat = d; v.cw = cw; v.cch = cch; v.clen = clen; v.clr = 1'b0;
      v.ev = 1'b1; v.ech = ch; v.edat = e;
      tbl.push_back(v);
      lch = ch; ldat = e;
   endtask

   // Idle vector (optionally a cfg write): outputs must hold.
   task automatic add_idle(input logic cw, input logic [CW-1:0] cch, input logic [AW-1:0] clen);
      vec_t v;
      v.iv = 1'b0; v.ich = '0; v.idat = '0; v.cw = cw; v.cch = cch; v.clen = clen; v.clr = 1'b0;
      v.ev = 1'b0; v.ech = lch; v.edat = ldat;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v, input bit chk, input string tag);
      @(negedge clk);
      in_valid = v.iv; in_ch = v.ich; in_data = v.idat;
      cfg_we = v.cw; cfg_ch = v.cch; cfg_len = v.clen; clear_req = v.clr;
      @(posedge clk);
      #1;
      if (chk) begin
         check({tag, " out_valid"}, 32'(out_valid), 32'(v.ev));
         check({tag, " out_ch"},    32'(out_ch),    32'(v.ech));
         check({tag, " out_data"},  32'(out_data),  32'(v.edat));
      end
   endtask

   function automatic vec_t mkv(input logic iv, input logic [CW-1:0] ch, input logic [DW-1:0] d,
                                input logic cw, input logic [CW-1:0] cch, input logic [AW-1:0] clen,
                                input logic clr, input logic [DW-1:0] e);
      vec_t v;
      v.iv = iv; v.ich = ch; v.idat = d; v.cw = cw; v.cch = cch; v.clen = clen; v.clr = clr;
      v.ev = iv; v.ech = ch; v.edat = e;
      return v;
   endfunction

   initial begin
      int cnt;
      int bad;
      vec_t v;

      // ---- vector table (applied after the reset sweep) ----
      lch = '0; ldat = '0;
      add_s(0, 18'h00123, 18'h00123, 0, 0, 0);            // len 0 bypass
      add_s(4, 18'h3ffff, 18'h3ffff, 0, 0, 0);
      add_idle(0, 0, 0);                                   // hold between strobes
      add_idle(1, 2, 5);                                   // len[2] = 5
      for (int i = 1; i <= 10; i++)
         add_s(2, 18'(i), (i > 5) ? 18'(i - 5) : 18'd0, 0, 0, 0);
      add_idle(0, 0, 0);
      add_idle(1, 1, 3);                                   // len[1] = 3
      add_idle(1, 7, 1);                                   // len[7] = 1
      for (int i = 0; i < 6; i++) begin
         add_s(1, 18'(12'h100 + i), (i >= 3) ? 18'(12'h100 + i - 3) : 18'd0, 0, 0, 0);
         add_s(7, 18'(12'h700 + i), (i >= 1) ? 18'(12'h700 + i - 1) : 18'd0, 0, 0, 0);
      end
      add_idle(0, 0, 0);
      add_idle(1, 3, 2);                                   // len[3] = 2
      add_s(3, 18'h31, 18'h0, 0, 0, 0);
      add_s(3, 18'h32, 18'h0, 0, 0, 0);
      add_s(3, 18'h33, 18'h31, 1, 3, 4);                   // cfg same cycle: old len 2
      add_s(3, 18'h34, 18'h0, 0, 0, 0);                    // len 4 reads an unwritten slot
      add_s(3, 18'h35, 18'h31, 0, 0, 0);
      add_s(2, 18'd11, 18'd6, 0, 0, 0);                    // ch2 untouched by the others
      add_s(0, 18'h55, 18'h55, 0, 0, 0);                   // ch0 still bypass
      add_idle(0, 0, 0);

      // ---- reset ----
      rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_len = '0; clear_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy",      32'(busy),      32'd1);
      check("reset in_ready",  32'(in_ready),  32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_ch",    32'(out_ch),    32'd0);
      check("reset out_data",  32'(out_data),  32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0; bad = 0;
      while (cnt < 20000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (in_ready) break;
         if (!busy) bad++;
      end
      check("sweep length", 32'(cnt), 32'(SWEEP));
      check("sweep busy gaps", 32'(bad), 32'd0);
      check("post-sweep busy", 32'(busy), 32'd0);

      // ---- table ----
      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // ---- long delay across the pointer wrap ----
      apply(mkv(0, 0, 0, 1, 0, 11'd2047, 0, 0), 1'b0, "cfg0");
      for (int n = 0; n < 2100; n++)
         apply(mkv(1, 0, 18'(n), 0, 0, 0, 0, (n >= 2047) ? 18'(n - 2047) : 18'd0),
               n >= 2047, $sformatf("wrap n%0d", n));

      // ---- clear with in_valid held high ----
      apply(mkv(0, 0, 0, 1, 5, 11'd3, 0, 0), 1'b0, "cfg5");
      for (int i = 0; i < 5; i++)
         apply(mkv(1, 5, 18'(12'h500 + i), 0, 0, 0, 0, (i >= 3) ? 18'(12'h500 + i - 3) : 18'd0),
               1'b1, $sformatf("fill5 %0d", i));
      apply(mkv(1, 5, 18'h5AA, 0, 0, 0, 1, 18'h502), 1'b1, "accept with clear_req");
      cnt = 0; bad = 0;
      while (cnt < 20000) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt == 100) clear_req = 1'b0;    // held high well into the sweep
         if (out_valid) bad++;
         if (in_ready) break;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("clear sweep length", 32'(cnt), 32'(SWEEP));
      check("out_valid during clear", 32'(bad), 32'd0);
      apply(mkv(1, 5, 18'h5B0, 0, 0, 0, 0, 18'h0),   1'b1, "post-clear 0");
      apply(mkv(1, 5, 18'h5B1, 0, 0, 0, 0, 18'h0),   1'b1, "post-clear 1");
      apply(mkv(1, 5, 18'h5B2, 0, 0, 0, 0, 18'h0),   1'b1, "post-clear 2");
      apply(mkv(1, 5, 18'h5B3, 0, 0, 0, 0, 18'h5B0), 1'b1, "post-clear len kept");

      // ---- reset mid-operation ----
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid reset busy",     32'(busy),     32'd1);
      check("mid reset in_ready", 32'(in_ready), 32'd0);
      check("mid reset out_data", 32'(out_data), 32'd0);
      check("mid reset out_ch",   32'(out_ch),   32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
